// File: rtl/huffman_decoder_if.sv
// huffman_decoder_if: serial code-bit input and decoded-symbol output handshakes
interface huffman_decoder_if #(
    parameter int SYM_BITS = 8
);
    logic                bit_in;
    logic                bit_valid;
    logic                bit_ready;
    logic [SYM_BITS-1:0] sym_out;
    logic                sym_valid;
    logic                sym_ready;
    modport master (output bit_in, bit_valid, sym_ready, input bit_ready, sym_out, sym_valid);
    modport slave  (input bit_in, bit_valid, sym_ready, output bit_ready, sym_out, sym_valid);
endinterface

// File: rtl/huffman_decoder.sv
// huffman_decoder: serial MSB-first Huffman decoder matching prefixes against a loadable code table
module huffman_decoder #(
    parameter int NUM_ENTRIES = 16,
    parameter int MAX_LEN     = 8,
    parameter int SYM_BITS    = 8,
    parameter int CNT_W       = 16,
    localparam int AW = $clog2(NUM_ENTRIES),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tbl_wr_en,
    input  logic [AW-1:0]       tbl_wr_addr,
    input  logic [LW-1:0]       tbl_wr_len,
    input  logic [MAX_LEN-1:0]  tbl_wr_code,
    input  logic [SYM_BITS-1:0] tbl_wr_sym,
    input  logic                start,
    input  logic                stop,
    huffman_decoder_if.slave    bs,
    output logic                err,
    output logic                busy,
    output logic [CNT_W-1:0]    sym_count
);
    typedef enum logic [1:0] {IDLE, SHIFT, EMIT, ERROR} state_t;
    state_t state, next_state;
    logic [LW-1:0]       tbl_len  [NUM_ENTRIES];
    logic [MAX_LEN-1:0]  tbl_code [NUM_ENTRIES];
    logic [SYM_BITS-1:0] tbl_sym  [NUM_ENTRIES];
    logic [MAX_LEN-2:0]  acc;
    logic [LW-1:0]       len, new_len;
    logic [MAX_LEN-1:0]  new_acc, mask;
    logic [SYM_BITS-1:0] sym_q, hit_sym;
    logic                hit, accept, full, handshake;

    assign accept    = state == SHIFT && bs.bit_valid;
    assign handshake = state == EMIT && bs.sym_ready;
    assign new_acc   = {acc, bs.bit_in};
    assign new_len   = len + 1'b1;
    assign mask      = ~({MAX_LEN{1'b1}} << new_len);
    assign full      = new_len == LW'(MAX_LEN);
    assign bs.sym_out = sym_q;

    // descending scan so the lowest matching index has the final say
    always_comb begin
        hit = 1'b0;
        hit_sym = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (tbl_len[i] == new_len && ((tbl_code[i] ^ new_acc) & mask) == '0) begin
                hit = 1'b1;
                hit_sym = tbl_sym[i];
            end
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= next_state;

    // stop beats start, and both beat any bit accept or symbol handshake
    always_comb
        next_state = stop ? IDLE :
                     start ? SHIFT :
                     accept ? (hit ? EMIT : full ? ERROR : SHIFT) :
                     handshake ? SHIFT : state;

    always_comb begin
        bs.bit_ready = state == SHIFT;
        bs.sym_valid = state == EMIT;
        busy         = state != IDLE;
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            acc       <= '0;
            len       <= '0;
            sym_q     <= '0;
            err       <= 1'b0;
            sym_count <= '0;
        end else if (!stop) begin
            if (start) begin
                acc       <= '0;
                len       <= '0;
                err       <= 1'b0;
                sym_count <= '0;
            end else begin
                if (accept) begin
                    acc <= new_acc[MAX_LEN-2:0];
                    len <= hit ? '0 : new_len;
                    err <= err | (!hit && full);
                    if (hit) sym_q <= hit_sym;
                end
                if (handshake) sym_count <= sym_count + 1'b1;
            end
        end

    // the table is only writable while no session is running
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_len[i]  <= '0;
                tbl_code[i] <= '0;
                tbl_sym[i]  <= '0;
            end
        end else if (tbl_wr_en && state == IDLE) begin
            tbl_len[tbl_wr_addr]  <= tbl_wr_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : tbl_wr_len;
            tbl_code[tbl_wr_addr] <= tbl_wr_code;
            tbl_sym[tbl_wr_addr]  <= tbl_wr_sym;
        end
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed vectors against a full decoder and a narrow-counter twin for wrap checks
module tb_huffman_decoder;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        tbl_wr_en = 1'b0;
    logic [3:0]  tbl_wr_addr = '0;
    logic [3:0]  tbl_wr_len = '0;
    logic [7:0]  tbl_wr_code = '0;
    logic [7:0]  tbl_wr_sym = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        err, busy, w_err, w_busy;
    logic [15:0] sym_count;
    logic [3:0]  w_count;
    int          vectors = 0;
    int          miscompares = 0;

    huffman_decoder_if #(.SYM_BITS(8)) bs();
    huffman_decoder_if #(.SYM_BITS(8)) ws();
    assign ws.bit_in    = bs.bit_in;
    assign ws.bit_valid = bs.bit_valid;
    assign ws.sym_ready = bs.sym_ready;

    huffman_decoder dut (
        .clk(clk), .n_rst(n_rst), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_len(tbl_wr_len), .tbl_wr_code(tbl_wr_code), .tbl_wr_sym(tbl_wr_sym),
        .start(start), .stop(stop), .bs(bs), .err(err), .busy(busy), .sym_count(sym_count)
    );

    // identical decoder with a 4-bit counter so wrap-around is reachable in a short run
    huffman_decoder #(.CNT_W(4)) u_wrap (
        .clk(clk), .n_rst(n_rst), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_len(tbl_wr_len), .tbl_wr_code(tbl_wr_code), .tbl_wr_sym(tbl_wr_sym),
        .start(start), .stop(stop), .bs(ws), .err(w_err), .busy(w_busy), .sym_count(w_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tbl_write(input logic [3:0] a, input logic [3:0] l, input logic [7:0] c, input logic [7:0] s);
        tbl_wr_en = 1'b1;
        tbl_wr_addr = a;
        tbl_wr_len = l;
        tbl_wr_code = c;
        tbl_wr_sym = s;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        bs.bit_in = b;
        bs.bit_valid = 1'b1;
        while (!bs.bit_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bs.bit_ready) chk("bit_ready_timeout", 32'(bs.bit_ready), 1);
        tick();
        bs.bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [7:0] code, input int len);
        for (int i = len - 1; i >= 0; i--) send_bit(code[i]);
    endtask

    task automatic expect_sym(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(bs.sym_valid), 1);
        chk({tag, "_sym"}, 32'(bs.sym_out), 32'(exp));
    endtask

    task automatic load_basic();
        tbl_write(0, 1, 8'b0, 8'h41);
        tbl_write(1, 2, 8'b10, 8'h42);
        tbl_write(2, 3, 8'b110, 8'h43);
        tbl_write(3, 3, 8'b111, 8'h44);
    endtask

    initial begin
        bs.bit_in = 1'b0;
        bs.bit_valid = 1'b0;
        bs.sym_ready = 1'b1;
        tick();
        chk("rst_bit_ready", 32'(bs.bit_ready), 0);
        chk("rst_sym_valid", 32'(bs.sym_valid), 0);
        chk("rst_sym_out", 32'(bs.sym_out), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(sym_count), 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        load_basic();
        pulse_start();
        chk("start_busy", 32'(busy), 1);
        chk("start_ready", 32'(bs.bit_ready), 1);
        send_code(8'b0, 1);
        expect_sym("basic_a", 8'h41);
        send_code(8'b10, 2);
        expect_sym("basic_b", 8'h42);
        send_code(8'b110, 3);
        expect_sym("basic_c", 8'h43);
        send_code(8'b111, 3);
        expect_sym("basic_d", 8'h44);
        tick();
        chk("basic_count", 32'(sym_count), 4);
        chk("basic_wcount", 32'(w_count), 4);
        chk("basic_err", 32'(err), 0);

        bs.sym_ready = 1'b0;
        send_code(8'b0, 1);
        expect_sym("bp_first", 8'h41);
        bs.bit_in = 1'b1;
        bs.bit_valid = 1'b1;
        repeat (5) begin
            tick();
            expect_sym("bp_hold", 8'h41);
            chk("bp_ready", 32'(bs.bit_ready), 0);
        end
        bs.bit_valid = 1'b0;
        bs.sym_ready = 1'b1;
        tick();
        chk("bp_count", 32'(sym_count), 5);
        send_code(8'b10, 2);
        expect_sym("bp_resume", 8'h42);
        tick();

        pulse_stop();
        chk("stop_busy", 32'(busy), 0);
        chk("stop_count_held", 32'(sym_count), 6);
        tbl_write(2, 0, 8'b0, 8'h00);
        tbl_write(3, 0, 8'b0, 8'h00);
        pulse_start();
        chk("restart_count", 32'(sym_count), 0);
        repeat (7) send_bit(1'b1);
        chk("err_pre", 32'(err), 0);
        send_bit(1'b1);
        chk("err_set", 32'(err), 1);
        chk("err_ready", 32'(bs.bit_ready), 0);
        chk("err_valid", 32'(bs.sym_valid), 0);
        tick();
        tick();
        chk("err_held", 32'(err), 1);
        chk("err_ready_held", 32'(bs.bit_ready), 0);
        pulse_start();
        chk("err_clear", 32'(err), 0);
        chk("err_restart_ready", 32'(bs.bit_ready), 1);

        tbl_write(0, 1, 8'b0, 8'h99);
        pulse_stop();
        pulse_start();
        send_code(8'b0, 1);
        expect_sym("gate", 8'h41);
        tick();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("stop_wins_busy", 32'(busy), 0);
        chk("stop_wins_count", 32'(sym_count), 1);

        tbl_write(2, 3, 8'b110, 8'h43);
        tbl_write(3, 3, 8'b111, 8'h44);
        pulse_start();
        send_bit(1'b1);
        send_bit(1'b1);
        pulse_start();
        chk("abort_ready", 32'(bs.bit_ready), 1);
        bs.sym_ready = 1'b0;
        send_bit(1'b0);
        expect_sym("abort", 8'h41);
        pulse_start();
        chk("abort_emit_valid", 32'(bs.sym_valid), 0);
        chk("abort_emit_count", 32'(sym_count), 0);
        bs.sym_ready = 1'b1;

        pulse_start();
        repeat (16) send_bit(1'b0);
        tick();
        chk("wrap16_count", 32'(sym_count), 16);
        chk("wrap16_wcount", 32'(w_count), 0);
        send_bit(1'b0);
        tick();
        chk("wrap17_count", 32'(sym_count), 17);
        chk("wrap17_wcount", 32'(w_count), 1);

        bs.sym_ready = 1'b0;
        send_bit(1'b0);
        expect_sym("pre_rst", 8'h41);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bs.sym_valid), 0);
        chk("arst_sym", 32'(bs.sym_out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(bs.bit_ready), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_count", 32'(sym_count), 0);
        @(negedge clk);
        n_rst = 1'b1;
        bs.sym_ready = 1'b1;
        tick();
        pulse_start();
        repeat (7) send_bit(1'b0);
        chk("cleared_tbl_pre", 32'(err), 0);
        send_bit(1'b0);
        chk("cleared_tbl_err", 32'(err), 1);
        chk("cleared_tbl_ready", 32'(bs.bit_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Serial Huffman bitstream decoder; the receive-side counterpart of the team's Huffman encoder path.
- Consumes code bits MSB-first over a valid/ready bit interface and matches the accumulated prefix against a software-loaded code table.
- Emits one decoded symbol per codeword over a valid/ready symbol interface.
- Maintains a wrapping decoded-symbol counter; sits between the bitstream source and the downstream byte sink.

Parameters:
- NUM_ENTRIES, 16, number of code table entries.
- MAX_LEN, 8, maximum codeword length in bits.
- SYM_BITS, 8, symbol width.
- Derived: AW = clog2(NUM_ENTRIES), LW = clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- tbl_wr_en  in  1  table write strobe
- tbl_wr_addr  in  AW  table entry index
- tbl_wr_len  in  LW  code length; 0 = entry invalid
- tbl_wr_code  in  MAX_LEN  code bits, right-justified (bit len-1 = first bit on the wire)
- tbl_wr_sym  in  SYM_BITS  symbol for this entry
- start  in  1  pulse: begin a new decode session
- stop  in  1  pulse: end session, return to IDLE
- bit_in  in  1  serial code bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  decoder accepts a bit this cycle
- sym_out  out  SYM_BITS  decoded symbol
- sym_valid  out  1  sym_out is valid
- sym_ready  in  1  downstream accepts the symbol
- err  out  1  sticky: no code matched within MAX_LEN bits
- busy  out  1  state != IDLE
- sym_count  out  16  symbols emitted this session, wraps at 65535 -> 0

Behaviour:
- Reset values:
  - State IDLE; acc = 0, len = 0.
  - All table lens = 0; sym_out = 0.
  - sym_valid, bit_ready, err, busy all 0; sym_count = 0.
- States: IDLE, SHIFT, EMIT, ERROR.
- Table writes:
  - Take effect only in IDLE; ignored in other states.
  - tbl_wr_len > MAX_LEN is stored saturated to MAX_LEN.
- IDLE:
  - start -> SHIFT next cycle.
  - On entry to SHIFT from start: acc, len, err and sym_count are cleared.
- SHIFT:
  - bit_ready = 1.
  - A bit is accepted when bit_valid && bit_ready: acc <= {acc[MAX_LEN-2:0], bit_in}, len <= len + 1.
  - Combinational match on the post-accept value:
    - An entry matches when entry.len == new len and entry.code[new len-1:0] == new acc[new len-1:0].
    - Any match -> EMIT; sym_out <= symbol of the lowest-index matching entry; len <= 0.
    - No match and new len == MAX_LEN -> ERROR, err <= 1.
  - Latency: sym_valid is asserted the cycle after the final bit of a codeword is accepted.
- EMIT:
  - sym_valid = 1, bit_ready = 0; sym_out is held stable until accepted.
  - sym_valid && sym_ready -> sym_count += 1, state -> SHIFT in the next cycle.
  - No bit is accepted in the handoff cycle; peak throughput is 1 bit/cycle within a codeword plus 1 cycle per symbol.
- ERROR:
  - bit_ready = 0, sym_valid = 0; err is held.
  - Exited only by start (-> SHIFT, err cleared) or stop (-> IDLE, err held until the next start).
- start in SHIFT/EMIT/ERROR:
  - Aborts the session: any pending symbol is dropped, acc/len/err/sym_count are cleared, state -> SHIFT.
- stop in any state:
  - State -> IDLE; partial code and pending symbol are discarded; sym_count and err are held.
- Priority:
  - start and stop in the same cycle -> stop wins.
  - start/stop win over bit accept and symbol handshake in the same cycle.
- bit_valid while bit_ready = 0: ignored; the source must hold the bit.
- Async reset mid-operation: all state returns to reset values immediately, including the table.

Test Plan:
- Basic decode:
  - Table: 0:{len1,"0",0x41}, 1:{len2,"10",0x42}, 2:{len3,"110",0x43}, 3:{len3,"111",0x44}; start.
  - Stream 0,1,0,1,1,0,1,1,1, sym_ready = 1 -> symbols 0x41, 0x42, 0x43, 0x44 in order; sym_count = 4; err = 0.
- Backpressure:
  - Same table; hold sym_ready = 0 for 5 cycles after the first symbol.
  - sym_valid stays 1, sym_out stable at 0x41, bit_ready = 0, no bits consumed; then decode resumes correctly.
- Error:
  - Table entries 0 and 1 only; stream eight 1s.
  - err = 1 in the cycle after the 8th bit; bit_ready = 0 thereafter; start clears err and returns to SHIFT.
- Table write gating:
  - Write entry 0 during SHIFT with sym 0x99; stop; send start, then bit 0.
  - Output is 0x41; the table is unchanged by the gated write.
- Abort and reset:
  - After 2 bits of "110", assert start -> next "0" decodes to 0x41.
  - Assert n_rst low mid-EMIT -> all outputs 0 immediately; table cleared, so after start no code matches and err is set after 8 bits.
- Counter wrap:
  - Decode 65537 "0" codewords -> sym_count = 1.
